// File: rtl/cdb_arbiter_pkg.sv
// Shared encodings for the CDB arbiter: commit op classes (same values as the ROB)
// and the bus source identifiers.
package cdb_arbiter_pkg;

    localparam int OP_W = 3;
    localparam int RD_W = 5;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_JUMP    = 3'd1,
        OP_BOTH    = 3'd2,
        OP_LOAD    = 3'd3,
        OP_STORE   = 3'd4,
        OP_NOTHING = 3'd5
    } op_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and the registered CDB broadcast.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    import cdb_arbiter_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [ROB_WIDTH-1:0] alu_tag;
    logic [OP_W-1:0]      alu_op;
    logic [RD_W-1:0]      alu_rd;
    logic [XLEN-1:0]      alu_wdata;
    logic [XLEN-1:0]      alu_jump;

    logic                 lsb_valid;
    logic                 lsb_ready;
    logic [ROB_WIDTH-1:0] lsb_tag;
    logic [XLEN-1:0]      lsb_wdata;

    logic                 cdb_valid;
    logic                 cdb_src;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [OP_W-1:0]      cdb_op;
    logic [RD_W-1:0]      cdb_rd;
    logic [XLEN-1:0]      cdb_wdata;
    logic [XLEN-1:0]      cdb_jump;

    modport master (
        output alu_valid, alu_tag, alu_op, alu_rd, alu_wdata, alu_jump,
        output lsb_valid, lsb_tag, lsb_wdata,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_tag, cdb_op, cdb_rd, cdb_wdata, cdb_jump
    );

    modport slave (
        input  alu_valid, alu_tag, alu_op, alu_rd, alu_wdata, alu_jump,
        input  lsb_valid, lsb_tag, lsb_wdata,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_tag, cdb_op, cdb_rd, cdb_wdata, cdb_jump
    );

endinterface

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO with flush; head is the registered oldest entry.
// A full FIFO refuses a push even when it pops in the same cycle.
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = en_in && !flush_in && push_in && (count_q != FULL);
        do_pop   = en_in && !flush_in && pop_in && (count_q != '0);
        if (en_in && flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Two-producer CDB arbiter: ALU and LSB results queue in small FIFOs, one is granted
// per cycle onto a registered bus. Define CDB_LSB_PRIO_EN for fixed LSB priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int FIFO_AW    = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_in,
    cdb_arbiter_if.slave bus
);

    localparam int          ALU_W = ROB_WIDTH + OP_W + RD_W + 2 * XLEN;
    localparam int          LSB_W = ROB_WIDTH + XLEN;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [ALU_W-1:0]     alu_head;
    logic [LSB_W-1:0]     lsb_head;
    logic [FIFO_AW:0]     alu_count, lsb_count;
    logic                 alu_pop, lsb_pop;
    logic                 alu_hv, lsb_hv;
    logic                 grant_alu, grant_lsb;

    logic [ROB_WIDTH-1:0] alu_h_tag, lsb_h_tag;
    logic [OP_W-1:0]      alu_h_op;
    logic [RD_W-1:0]      alu_h_rd;
    logic [XLEN-1:0]      alu_h_wdata, alu_h_jump, lsb_h_wdata;

    src_e                 rr_last_q, rr_last_d;
    logic                 cdb_valid_q, cdb_valid_d;
    src_e                 cdb_src_q, cdb_src_d;
    logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
    logic [OP_W-1:0]      cdb_op_q, cdb_op_d;
    logic [RD_W-1:0]      cdb_rd_q, cdb_rd_d;
    logic [XLEN-1:0]      cdb_wdata_q, cdb_wdata_d;
    logic [XLEN-1:0]      cdb_jump_q, cdb_jump_d;

    cdb_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_alu_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_in    (rdy_in),
        .flush_in (clear_in),
        .push_in  (bus.alu_valid),
        .pop_in   (alu_pop),
        .din      ({bus.alu_tag, bus.alu_op, bus.alu_rd, bus.alu_wdata, bus.alu_jump}),
        .head     (alu_head),
        .count    (alu_count)
    );

    cdb_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_lsb_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_in    (rdy_in),
        .flush_in (clear_in),
        .push_in  (bus.lsb_valid),
        .pop_in   (lsb_pop),
        .din      ({bus.lsb_tag, bus.lsb_wdata}),
        .head     (lsb_head),
        .count    (lsb_count)
    );

    assign {alu_h_tag, alu_h_op, alu_h_rd, alu_h_wdata, alu_h_jump} = alu_head;
    assign {lsb_h_tag, lsb_h_wdata} = lsb_head;
    assign alu_hv = (alu_count != '0);
    assign lsb_hv = (lsb_count != '0);

    assign bus.alu_ready = rdy_in && (alu_count != FULL);
    assign bus.lsb_ready = rdy_in && (lsb_count != FULL);

    always_comb begin
`ifdef CDB_LSB_PRIO_EN
        grant_lsb = lsb_hv;
        grant_alu = alu_hv && !lsb_hv;
`else
        if (alu_hv && lsb_hv) begin
            grant_alu = (rr_last_q == SRC_LSB);
            grant_lsb = !grant_alu;
        end else begin
            grant_alu = alu_hv;
            grant_lsb = lsb_hv;
        end
`endif
    end

    always_comb begin
        alu_pop     = 1'b0;
        lsb_pop     = 1'b0;
        rr_last_d   = rr_last_q;
        cdb_valid_d = cdb_valid_q;
        cdb_src_d   = cdb_src_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_op_d    = cdb_op_q;
        cdb_rd_d    = cdb_rd_q;
        cdb_wdata_d = cdb_wdata_q;
        cdb_jump_d  = cdb_jump_q;
        // Every enabled cycle rewrites the whole bus; idle or flushed cycles drive zeros.
        if (rdy_in) begin
            cdb_valid_d = 1'b0;
            cdb_src_d   = SRC_ALU;
            cdb_tag_d   = '0;
            cdb_op_d    = '0;
            cdb_rd_d    = '0;
            cdb_wdata_d = '0;
            cdb_jump_d  = '0;
            if (!clear_in) begin
                if (grant_alu) begin
                    alu_pop     = 1'b1;
                    cdb_valid_d = 1'b1;
                    cdb_src_d   = SRC_ALU;
                    cdb_tag_d   = alu_h_tag;
                    cdb_op_d    = alu_h_op;
                    cdb_rd_d    = alu_h_rd;
                    cdb_wdata_d = alu_h_wdata;
                    cdb_jump_d  = alu_h_jump;
`ifndef CDB_LSB_PRIO_EN
                    rr_last_d   = SRC_ALU;
`endif
                end else if (grant_lsb) begin
                    lsb_pop     = 1'b1;
                    cdb_valid_d = 1'b1;
                    cdb_src_d   = SRC_LSB;
                    cdb_tag_d   = lsb_h_tag;
                    cdb_op_d    = OP_LOAD;
                    cdb_wdata_d = lsb_h_wdata;
`ifndef CDB_LSB_PRIO_EN
                    rr_last_d   = SRC_LSB;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_last_q   <= SRC_LSB;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= SRC_ALU;
            cdb_tag_q   <= '0;
            cdb_op_q    <= '0;
            cdb_rd_q    <= '0;
            cdb_wdata_q <= '0;
            cdb_jump_q  <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_op_q    <= cdb_op_d;
            cdb_rd_q    <= cdb_rd_d;
            cdb_wdata_q <= cdb_wdata_d;
            cdb_jump_q  <= cdb_jump_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_op    = cdb_op_q;
    assign bus.cdb_rd    = cdb_rd_q;
    assign bus.cdb_wdata = cdb_wdata_q;
    assign bus.cdb_jump  = cdb_jump_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single result/writeback bus (CDB) into the reorder buffer and the RS operand-update path.
- Two producers feed the bus: the ALU reservation-station result path and the load/store-buffer load-data path.
- Each producer has a small FIFO so it can retire a result even when it loses arbitration.
- One result is granted per cycle, round-robin, onto a registered bus; a pipeline clear flushes all pending results.

Parameters:
- ROB_WIDTH, 4, tag width (ROB index bits)
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, at least 2
- FIFO_AW, 1, log2(FIFO_DEPTH)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- clear_in  in  1  pipeline flush from the ROB commit stage
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_tag  in  ROB_WIDTH  ROB entry of the result
- alu_op  in  3  commit class: WRITE/JUMP/BOTH/LOAD/STORE/NOTHING
- alu_rd  in  5  destination register
- alu_wdata  in  32  result value
- alu_jump  in  32  redirect target
- lsb_valid  in  1  load data offered
- lsb_ready  out  1  LSB FIFO can accept
- lsb_tag  in  ROB_WIDTH  ROB entry of the load
- lsb_wdata  in  32  loaded value
- cdb_valid  out  1  bus carries a result this cycle
- cdb_src  out  1  0 = ALU, 1 = LSB
- cdb_tag  out  ROB_WIDTH  granted tag
- cdb_op  out  3  granted op
- cdb_rd  out  5  granted rd
- cdb_wdata  out  32  granted value
- cdb_jump  out  32  granted jump target

Behaviour:
- Reset (async): both FIFOs empty; rr_last = LSB, so the ALU wins the first tie. cdb_valid = 0; cdb_src, cdb_tag, cdb_op, cdb_rd, cdb_wdata and cdb_jump = 0.
- Ready outputs: x_ready = rdy_in && count_x != FIFO_DEPTH, combinational.
  - A push happens at the clock edge when x_valid && x_ready && !clear_in.
  - A full FIFO does not accept a push, even if it pops in the same cycle.
- FIFO pointers are FIFO_AW bits wide and wrap naturally; each count is FIFO_AW+1 bits.
- Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- Arbitration looks only at the registered FIFO heads; there is no empty-FIFO bypass.
  - Minimum latency is push at edge N, cdb_valid high after edge N+1.
  - Both heads valid: grant the source other than rr_last, then rr_last <= granted source.
  - One head valid: grant it; rr_last is updated the same way.
  - Neither valid: cdb_valid <= 0; rr_last is held.
- Bus output is registered and fully replaced every enabled cycle. cdb_valid is a one-cycle pulse per grant; there is no downstream backpressure, because the ROB always accepts.
- LSB entries drive the bus with cdb_op = LOAD(3'b011), cdb_rd = 0, cdb_jump = 0.
- clear_in high at an enabled edge:
  - both FIFOs are emptied;
  - cdb_valid <= 0;
  - any same-cycle pushes are dropped;
  - rr_last is held.
  - clear_in has priority over every other event.
- rdy_in low: no push, no pop, no clear; all registers, including cdb_*, hold their values.
- Reset asserted in the middle of any operation returns everything to the reset values immediately.

Optional Feature:
- CDB_LSB_PRIO_EN defined: fixed priority; the LSB head always wins over the ALU head, and rr_last is unused and held at reset value. This shortens load-to-commit latency.
- Undefined: round-robin as described above.

Decomposition:
- Shared package / include:
  - op encodings WRITE=0, JUMP=1, BOTH=2, LOAD=3, STORE=4, NOTHING=5, using the same values as the ROB;
  - source encodings SRC_ALU=0, SRC_LSB=1.
- Sub-module cdb_fifo: parameterized width and depth, with push/pop/flush, a count output and a head output.
  - The ALU instance is ROB_WIDTH+3+5+32+32 bits wide.
  - The LSB instance is ROB_WIDTH+32 bits wide.

Test Plan:
- Single ALU push (tag 5, op WRITE, rd 3, wdata 0x12345678) in an idle cycle -> next cycle cdb_valid=1, src=0, tag=5, rd=3, wdata=0x12345678; the following cycle cdb_valid=0.
- Simultaneous ALU (tag 1) and LSB (tag 2) pushes, then both again (tags 3, 4) -> bus order is tags 1, 2, 3, 4 with src alternating 0, 1, 0, 1. With CDB_LSB_PRIO_EN the order is 2, 4, 1, 3.
- LSB FIFO fill: push every cycle while ALU results keep winning -> lsb_ready drops after two unserved entries. A push attempted while full is not stored, and exactly 2 LSB results later appear on the bus.
- clear_in with both FIFOs full (4 entries) plus a same-cycle ALU push -> no cdb_valid afterwards; both ready signals high the next cycle.
- rdy_in low for 3 cycles while cdb_valid=1 with tag 7 -> outputs hold tag 7 and cdb_valid stays 1; no pops occur. After rdy_in rises, arbitration resumes from the held state.
- Async rst_in pulse mid-cycle while the FIFOs hold data -> cdb_valid=0 and both ready signals go high immediately. The next simultaneous pushes grant the ALU first.
